// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// Lock inputs exist only when MEM_ARB_LOCK_EN is defined.
interface data_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              p0_req;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_word_we;
  logic              p0_byte_we;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_word_we;
  logic              p1_byte_we;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;

`ifdef MEM_ARB_LOCK_EN
  logic              p0_lock;
  logic              p1_lock;
`endif

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_word_we;
  logic              mem_byte_we;
  logic [DATA_W-1:0] mem_data_out;

  // Arbiter side.
  modport slave (
`ifdef MEM_ARB_LOCK_EN
    input  p0_lock, p1_lock,
`endif
    input  p0_req, p0_addr, p0_wdata, p0_word_we, p0_byte_we,
    output p0_ack, p0_rdata,
    input  p1_req, p1_addr, p1_wdata, p1_word_we, p1_byte_we,
    output p1_ack, p1_rdata,
    output mem_addr, mem_data_in, mem_word_we, mem_byte_we,
    input  mem_data_out
  );

  // Requester/memory side.
  modport master (
`ifdef MEM_ARB_LOCK_EN
    output p0_lock, p1_lock,
`endif
    output p0_req, p0_addr, p0_wdata, p0_word_we, p0_byte_we,
    input  p0_ack, p0_rdata,
    output p1_req, p1_addr, p1_wdata, p1_word_we, p1_byte_we,
    input  p1_ack, p1_rdata,
    input  mem_addr, mem_data_in, mem_word_we, mem_byte_we,
    output mem_data_out
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between two requesters.
// Optional MEM_ARB_LOCK_EN adds a one-extra-grant lock for read-modify-write sequences.
module data_mem_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input logic               clk,
  input logic               reset,
  data_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StG0, StG1} grant_e;

  grant_e grant_q, grant_d;
  logic   last_q, last_d;  // 0: port 0 served last, 1: port 1

  logic              ack0, ack1;
  logic              r0, r1;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] din_mux;
  logic              word_we, byte_we;

`ifdef MEM_ARB_LOCK_EN
  logic locked_q, locked_d;
`endif

  always_comb begin
    addr_mux = '0;
    din_mux  = '0;
    word_we  = 1'b0;
    byte_we  = 1'b0;
    ack0     = 1'b0;
    ack1     = 1'b0;
    if (!reset) begin
      unique case (grant_q)
        StG0: begin
          addr_mux = bus.p0_addr;
          din_mux  = bus.p0_wdata;
          word_we  = bus.p0_req & bus.p0_word_we;
          byte_we  = bus.p0_req & bus.p0_byte_we & ~bus.p0_word_we;
          ack0     = bus.p0_req;
        end
        StG1: begin
          addr_mux = bus.p1_addr;
          din_mux  = bus.p1_wdata;
          word_we  = bus.p1_req & bus.p1_word_we;
          byte_we  = bus.p1_req & bus.p1_byte_we & ~bus.p1_word_we;
          ack1     = bus.p1_req;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr    = addr_mux;
  assign bus.mem_data_in = din_mux;
  assign bus.mem_word_we = word_we;
  assign bus.mem_byte_we = byte_we;
  assign bus.p0_ack      = ack0;
  assign bus.p1_ack      = ack1;
  assign bus.p0_rdata    = bus.mem_data_out;
  assign bus.p1_rdata    = bus.mem_data_out;

  // A request acked this cycle has completed and must not compete again.
  assign r0 = bus.p0_req & ~ack0;
  assign r1 = bus.p1_req & ~ack1;

  always_comb begin
    grant_d = StIdle;
    last_d  = last_q;
    if (r0 && r1) begin
      grant_d = last_q ? StG0 : StG1;
    end else if (r0) begin
      grant_d = StG0;
    end else if (r1) begin
      grant_d = StG1;
    end
    if (grant_d == StG0) last_d = 1'b0;
    if (grant_d == StG1) last_d = 1'b1;
`ifdef MEM_ARB_LOCK_EN
    locked_d = 1'b0;
    if (ack0 && bus.p0_lock && !locked_q) begin
      grant_d  = StG0;
      last_d   = last_q;
      locked_d = 1'b1;
    end else if (ack1 && bus.p1_lock && !locked_q) begin
      grant_d  = StG1;
      last_d   = last_q;
      locked_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

`ifdef MEM_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      locked_q <= 1'b0;
    end else begin
      locked_q <= locked_d;
    end
  end
`endif
endmodule
